piso_serializer: RTL
====================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the dff sampling stage.
//  Accepts a WIDTH-bit word over a valid/ready handshake and drives one bit
//  per clk on dout, which feeds the dff's din. Provides busy and a per-word
//  done pulse. An even-parity bit can optionally be appended to each word.
// PARAMETERS
//  WIDTH      8  word width in bits; legal range 2..32
//  MSB_FIRST  1  1: shift load_data[WIDTH-1] first; 0: shift load_data[0] first
//  IDLE_LEVEL 0  value driven on dout while no word is being shifted
// PORTS
//  clk         in   1      single clock; all logic on posedge
//  rst         in   1      synchronous reset, active-high
//  load_valid  in   1      upstream has a word on load_data
//  load_data   in   WIDTH  word to serialise; sampled on accept edge only
//  load_ready  out  1      block can accept a word this cycle
//  dout        out  1      serial bit, registered (drives dff din)
//  dout_valid  out  1      dout carries a data or parity bit
//  busy        out  1      word in flight (state != IDLE)
//  done        out  1      1-cycle pulse, concurrent with final bit of word
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, dout=IDLE_LEVEL, dout_valid=0,
//    busy=0, done=0, load_ready=1, bit counter=0, shift reg=0.
//  - Reset mid-word: word is discarded; at the next edge all outputs take reset values.
//  - Accept = load_valid && load_ready at a posedge. load_data is captured
//    into the shift register. Upstream holds load_valid/load_data until accepted.
//  - load_valid while load_ready=0: ignored; no state change.
//  - FSM states IDLE, SHIFT, PARITY (PARITY exists only with PAR_EN).
//    IDLE --accept--> SHIFT. SHIFT --last data bit, no PAR_EN, no accept--> IDLE.
//    SHIFT --last data bit, PAR_EN--> PARITY. PARITY --no accept--> IDLE.
//    Last output bit + accept --> SHIFT (back-to-back word).
//  - Latency: accept at edge N -> first bit on dout for cycle after edge N.
//    Last data bit is on dout for cycle after edge N+WIDTH-1 (WIDTH bit times).
//  - dout_valid=1 for every data/parity bit cycle, else 0.
//  - Bit counter is $clog2(WIDTH)+1 bits. It clears on accept and increments
//    per data bit. It never wraps past WIDTH-1.
//  - load_ready = (state==IDLE) || (last output bit of the word is on dout).
//    This allows gapless back-to-back words with dout_valid held at 1.
//  - done=1 exactly in the cycle the word's final bit (data or parity) is on dout.
//  - busy=1 whenever state!=IDLE, including the final-bit cycle.
//  - Simultaneous rst and load_valid: rst wins; the word is not accepted.
// CONFIGURATION
//  PISO_PARITY_EN defined: one extra bit after the data bits (PARITY state).
//    That bit is the even-parity bit, ^captured_word. Word length = WIDTH+1 cycles.
//    done and load_ready move to the parity cycle.
//  PISO_PARITY_EN undefined: no PARITY state or parity logic. Word length = WIDTH.
// TESTING
//  1 Reset with rst=1 for 2 cycles -> dout=0, dout_valid=0, busy=0, load_ready=1, done=0.
//  2 WIDTH=8, MSB_FIRST=1, load 8'hA5 -> dout sequence 1,0,1,0,0,1,0,1 on
//    8 consecutive cycles; done=1 only on the 8th cycle; IDLE after.
//  3 Back-to-back: 8'hA5 then 8'h3C with valid held -> 16 contiguous bits
//    10100101 00111100; dout_valid never drops; done pulses on cycles 8 and 16.
//  4 Reset mid-word: rst=1 during 3rd bit of 8'hFF -> next cycle dout=0,
//    dout_valid=0, load_ready=1; the remaining bits never appear.
//  5 MSB_FIRST=0, load 8'h01 -> dout 1,0,0,0,0,0,0,0; while busy, load_valid
//    with 8'hFF is ignored until load_ready and accepted afterwards.
//  6 PISO_PARITY_EN, load 8'h07 -> 8 data bits then parity bit 1 (9th cycle,
//    done=1). Load 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out shifter with busy and per-word done.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of each word.
module piso_serializer #(
    parameter int   WIDTH      = 8,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;
`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    logic par;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    state_t           state, state_nx;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             accept, last_data, last;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w << 1 : w >> 1;
    endfunction

    // last is true while the word's final bit (data or parity) is on dout
    always_comb begin
        last_data = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
        last = (state == PARITY);
`else
        last = last_data;
`endif
        accept   = load_valid && load_ready;
        state_nx = accept ? SHIFT : last ? IDLE : state;
`ifdef PISO_PARITY_EN
        if (last_data) state_nx = PARITY;
`endif
    end

    assign load_ready = (state == IDLE) || last;
    assign busy       = (state != IDLE);
    assign done       = last;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg       <= '0;
            cnt        <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (accept) begin
            dout       <= head(load_data);
            sreg       <= advance(load_data);
            cnt        <= '0;
            dout_valid <= 1'b1;
`ifdef PISO_PARITY_EN
            par        <= ^load_data;
`endif
        end else if (state == SHIFT && !last_data) begin
            dout <= head(sreg);
            sreg <= advance(sreg);
            cnt  <= cnt + 1'b1;
`ifdef PISO_PARITY_EN
        end else if (last_data) begin
            dout <= par;
`endif
        end else if (last) begin
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
        end
    end
endmodule
